maquina_vendas_param: RTL and testbench
=======================================

Name: maquina_vendas_param

Overview:
Parametrised vending-machine controller that replaces the fixed 4x4 keypad/coin top-level datapath with one sequential block. It accepts a two-keystroke product selection (row, column) on a ROWS x COLS grid and fetches the price from an external price table through a registered lookup port. It accumulates coin credit with saturation, then dispenses, refunds, or returns change. Inactivity timeout and cancel are handled inside the block. It sits between the keypad encoder/coin acceptor and the display/actuator drivers.

Parameters:
ROWS, 4, product grid rows (2..16)
COLS, 4, product grid columns (2..16)
KEY_W, 4, keypad code width; must satisfy 2**KEY_W >= max(ROWS,COLS)
CREDIT_W, 8, credit/price/change width in coin units
TIMEOUT_CYC, 30, idle cycles before abort in SEL_COL or PAY
PULSE_CYC, 4, cycles that dispense/refund outputs are held high

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  KEY_W  keypad digit
coin_valid  in  1  one-cycle strobe, coin inserted
coin_code  in  2  coin type: 00=1, 01=2, 10=5, 11=10 units
cancel  in  1  one-cycle strobe, user abort
price_row  out  KEY_W  lookup row (registered)
price_col  out  KEY_W  lookup column (registered)
price_val  in  CREDIT_W  price for {price_row,price_col}, valid the cycle after price_row/price_col change
price_exists  in  1  product slot populated
credit  out  CREDIT_W  current accumulated credit
product  out  2*KEY_W  selected {row,col}
state  out  3  FSM state encoding, for display
dispense  out  1  release product, held PULSE_CYC cycles
refund  out  1  return all credit, held PULSE_CYC cycles
change  out  CREDIT_W  change amount, valid while dispense is high
coin_reject  out  1  one-cycle pulse, coin refused
sel_error  out  1  one-cycle pulse, invalid/empty selection

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, credit=0, product=0, price_row/price_col=0, every output pulse=0, change=0, timeout counter=0.
- Encoding: IDLE=0, SEL_COL=1, LOOKUP=2, PAY=3, DISPENSE=4, REFUND=5.
- IDLE: on key_valid with key_code<ROWS, latch row and go to SEL_COL. On key_code>=ROWS, pulse sel_error and stay in IDLE. Coins in IDLE are accepted into credit.
- SEL_COL: on key_valid with key_code<COLS, latch col, drive price_row/price_col, and go to LOOKUP. On key_code>=COLS, pulse sel_error and return to IDLE.
- LOOKUP: one cycle. If price_exists=0, pulse sel_error and go to REFUND if credit>0, else IDLE. Otherwise latch price_val and go to PAY.
- PAY: when credit>=price, go to DISPENSE on the next cycle. The check also runs on the cycle of entry, so credit already inserted dispenses with 1-cycle latency.
- DISPENSE: dispense=1 for PULSE_CYC cycles. Afterwards credit is cleared to 0 and the FSM returns to IDLE.
- REFUND: refund=1 for PULSE_CYC cycles. Afterwards credit is cleared to 0 and the FSM returns to IDLE.
- Credit arithmetic: a coin value is added the cycle after coin_valid.
  - If the sum would exceed 2**CREDIT_W-1, the coin is not added and coin_reject pulses.
  - Coins in DISPENSE, REFUND or LOOKUP are rejected.
- Timeout: the counter resets on any key_valid, coin_valid or state change. In SEL_COL or PAY, reaching TIMEOUT_CYC goes to REFUND if credit>0, else IDLE.
- cancel: in SEL_COL, LOOKUP or PAY, go to REFUND if credit>0, else IDLE. Ignored in IDLE, DISPENSE and REFUND.
- Simultaneous events: priority is cancel > timeout > key > coin evaluation for transitions. A coin arriving together with cancel is still credited and then refunded.
- key_valid in LOOKUP, PAY, DISPENSE or REFUND is ignored.

Optional Feature:
CHANGE_EN defined: on entering DISPENSE, change=credit-price and is held for the pulse duration.
CHANGE_EN undefined: change is tied to 0 and excess credit is forfeited on dispense (legacy behaviour).

Decomposition:
- Shared package maquina_pkg holds:
  - state enum
  - coin_code enum and the coin-value function mapping 2-bit code to units
  - PULSE_CYC default
- One natural sub-module: timeout_cnt_param.
  - Parametrised by TIMEOUT_CYC.
  - Ports: clk, reset_n, restart, enable, expired.
  - Reused for the PULSE_CYC hold counter.

Test Plan:
- Exact payment: key 2, key 3, price_val=7 exists; coins 5,2 -> dispense high 4 cycles, change=0, credit 0 after, state back to IDLE.
- Overpay (CHANGE_EN): credit 10 before selection; select price 7 -> DISPENSE 1 cycle after PAY entry, change=3. With CHANGE_EN undefined, change=0.
- Invalid/empty selection: key 5 with ROWS=4 -> sel_error pulse, state IDLE. Valid row/col with price_exists=0 and credit 2 -> sel_error, refund 4 cycles, credit 0.
- Timeout: select a valid product, insert 1, then no activity 30 cycles -> REFUND, refund high 4 cycles.
- Saturation: CREDIT_W=4, credit 10, insert coin 10 -> coin_reject pulse, credit stays 10.
- Reset mid-operation: reset_n=0 during DISPENSE -> next edge dispense=0, credit=0, state IDLE. Cancel and coin in the same cycle in PAY -> coin credited, then refund.

Source files
------------

// File: rtl/maquina_pkg.sv
// Shared types and helpers for the maquina_vendas_param vending controller.
package maquina_pkg;

   localparam int unsigned PULSE_CYC_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEL_COL  = 3'd1,
      ST_LOOKUP   = 3'd2,
      ST_PAY      = 3'd3,
      ST_DISPENSE = 3'd4,
      ST_REFUND   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      COIN_1  = 2'b00,
      COIN_2  = 2'b01,
      COIN_5  = 2'b10,
      COIN_10 = 2'b11
   } coin_t;

   // Coin code to value in coin units.
   function automatic logic [3:0] coin_value(input logic [1:0] code);
      case (coin_t'(code))
         COIN_1:  return 4'd1;
         COIN_2:  return 4'd2;
         COIN_5:  return 4'd5;
         default: return 4'd10;
      endcase
   endfunction

endpackage

// File: rtl/timeout_cnt_param.sv
// Restartable cycle counter: o_expired rises during the TIMEOUT_CYC-th enabled
// cycle after the restart edge and stays high until the next restart.
// Used both for the inactivity timeout and the dispense/refund hold time.
module timeout_cnt_param #(
   parameter int unsigned TIMEOUT_CYC = 30
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_restart,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_expired;

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // Count enabled cycles since the last restart, saturating at expiry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else if (i_restart) begin
         r_cnt     <= '0;
         r_expired <= (LIMIT == 0);
      end else if (i_enable && !r_expired) begin
         r_cnt     <= w_cnt_inc;
         r_expired <= (w_cnt_inc == CNT_W'(LIMIT));
      end
   end

   assign o_expired = r_expired;

endmodule

// File: rtl/maquina_vendas_param.sv
// Parametrised vending-machine controller: two-key product selection,
// registered price lookup, saturating coin credit, dispense/refund pulses.
// Optional macro CHANGE_EN: when defined, o_change carries credit-price
// for the duration of the dispense pulse; otherwise o_change is 0.
module maquina_vendas_param
   import maquina_pkg::*;
#(
   parameter int unsigned ROWS        = 4,
   parameter int unsigned COLS        = 4,
   parameter int unsigned KEY_W       = 4,
   parameter int unsigned CREDIT_W    = 8,
   parameter int unsigned TIMEOUT_CYC = 30,
   parameter int unsigned PULSE_CYC   = PULSE_CYC_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_key_valid,
   input  logic [KEY_W-1:0]      i_key_code,
   input  logic                  i_coin_valid,
   input  logic [1:0]            i_coin_code,
   input  logic                  i_cancel,
   output logic [KEY_W-1:0]      o_price_row,
   output logic [KEY_W-1:0]      o_price_col,
   input  logic [CREDIT_W-1:0]   i_price_val,
   input  logic                  i_price_exists,
   output logic [CREDIT_W-1:0]   o_credit,
   output logic [2*KEY_W-1:0]    o_product,
   output logic [2:0]            o_state,
   output logic                  o_dispense,
   output logic                  o_refund,
   output logic [CREDIT_W-1:0]   o_change,
   output logic                  o_coin_reject,
   output logic                  o_sel_error
);

   localparam int unsigned SUM_W = CREDIT_W + 1;

   state_t              r_state, w_state_nx, w_abort_st;
   logic [KEY_W-1:0]    r_row, r_col, r_price_row, r_price_col;
   logic [CREDIT_W-1:0] r_credit, r_price, w_credit_nx;
   logic [SUM_W-1:0]    w_sum;
   logic                r_dispense, r_refund, r_coin_reject, r_sel_error;
   logic                w_coin_ok, w_coin_reject, w_coin_state_ok;
   logic                w_sel_error, w_latch_row, w_latch_col, w_latch_price, w_clear_credit;
   logic                w_row_ok, w_col_ok, w_state_chg;
   logic                w_to_expired, w_pulse_expired;
   logic                w_to_restart, w_to_enable, w_pulse_enable;

   assign w_row_ok = (32'(i_key_code) < ROWS);
   assign w_col_ok = (32'(i_key_code) < COLS);

   // Coin acceptance and the credit value after this cycle's coin.
   always_comb begin
      w_sum           = {1'b0, r_credit} + SUM_W'(coin_value(i_coin_code));
      w_coin_state_ok = (r_state == ST_IDLE) || (r_state == ST_SEL_COL) || (r_state == ST_PAY);
      w_coin_ok       = i_coin_valid && w_coin_state_ok && !w_sum[CREDIT_W];
      w_coin_reject   = i_coin_valid && !w_coin_ok;
      w_credit_nx     = w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;
   end

   // Next-state and control decode; priority cancel > timeout > key > coin.
   always_comb begin
      w_state_nx     = r_state;
      w_sel_error    = 1'b0;
      w_latch_row    = 1'b0;
      w_latch_col    = 1'b0;
      w_latch_price  = 1'b0;
      w_clear_credit = 1'b0;
      w_abort_st     = (w_credit_nx != '0) ? ST_REFUND : ST_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (i_key_valid) begin
               if (w_row_ok) begin
                  w_latch_row = 1'b1;
                  w_state_nx  = ST_SEL_COL;
               end else begin
                  w_sel_error = 1'b1;
               end
            end
         end
         ST_SEL_COL: begin
            if (i_cancel || w_to_expired) begin
               w_state_nx = w_abort_st;
            end else if (i_key_valid) begin
               if (w_col_ok) begin
                  w_latch_col = 1'b1;
                  w_state_nx  = ST_LOOKUP;
               end else begin
                  w_sel_error = 1'b1;
                  w_state_nx  = ST_IDLE;
               end
            end
         end
         ST_LOOKUP: begin
            if (i_cancel) begin
               w_state_nx = w_abort_st;
            end else if (!i_price_exists) begin
               w_sel_error = 1'b1;
               w_state_nx  = w_abort_st;
            end else begin
               w_latch_price = 1'b1;
               w_state_nx    = ST_PAY;
            end
         end
         ST_PAY: begin
            if (i_cancel || w_to_expired) begin
               w_state_nx = w_abort_st;
            end else if (r_credit >= r_price) begin
               w_state_nx = ST_DISPENSE;
            end
         end
         ST_DISPENSE, ST_REFUND: begin
            if (w_pulse_expired) begin
               w_clear_credit = 1'b1;
               w_state_nx     = ST_IDLE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   assign w_state_chg    = (w_state_nx != r_state);
   assign w_to_restart   = i_key_valid || i_coin_valid || w_state_chg;
   assign w_to_enable    = (r_state == ST_SEL_COL) || (r_state == ST_PAY);
   assign w_pulse_enable = (r_state == ST_DISPENSE) || (r_state == ST_REFUND);

   timeout_cnt_param #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_restart (w_to_restart),
      .i_enable  (w_to_enable),
      .o_expired (w_to_expired)
   );

   timeout_cnt_param #(.TIMEOUT_CYC(PULSE_CYC)) u_pulse (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_restart (w_state_chg),
      .i_enable  (w_pulse_enable),
      .o_expired (w_pulse_expired)
   );

   // State, credit, selection and pulse registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_credit      <= '0;
         r_price       <= '0;
         r_row         <= '0;
         r_col         <= '0;
         r_price_row   <= '0;
         r_price_col   <= '0;
         r_dispense    <= 1'b0;
         r_refund      <= 1'b0;
         r_coin_reject <= 1'b0;
         r_sel_error   <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_credit      <= w_clear_credit ? '0 : w_credit_nx;
         r_dispense    <= (w_state_nx == ST_DISPENSE);
         r_refund      <= (w_state_nx == ST_REFUND);
         r_coin_reject <= w_coin_reject;
         r_sel_error   <= w_sel_error;
         if (w_latch_row) r_row <= i_key_code;
         if (w_latch_col) begin
            r_col       <= i_key_code;
            r_price_row <= r_row;
            r_price_col <= i_key_code;
         end
         if (w_latch_price) r_price <= i_price_val;
      end
   end

`ifdef CHANGE_EN
   logic [CREDIT_W-1:0] r_change;

   // Capture change on entry to DISPENSE and hold it for the pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_change <= '0;
      end else if ((w_state_nx == ST_DISPENSE) && (r_state != ST_DISPENSE)) begin
         r_change <= w_credit_nx - r_price;
      end else if (w_state_nx != ST_DISPENSE) begin
         r_change <= '0;
      end
   end

   assign o_change = r_change;
`else
   assign o_change = '0;
`endif

   assign o_state       = r_state;
   assign o_credit      = r_credit;
   assign o_product     = {r_row, r_col};
   assign o_price_row   = r_price_row;
   assign o_price_col   = r_price_col;
   assign o_dispense    = r_dispense;
   assign o_refund      = r_refund;
   assign o_coin_reject = r_coin_reject;
   assign o_sel_error   = r_sel_error;

endmodule

// File: tb/tb_maquina_vendas_param.sv
// Self-checking bench for maquina_vendas_param: directed scenarios plus
// randomized purchases checked against a transaction-level outcome model.
module tb_maquina_vendas_param;

   localparam int unsigned ROWS = 4, COLS = 4, KEY_W = 4, CREDIT_W = 8;
   localparam int unsigned TO_CYC = 30, PULSE = 4;
   localparam logic [2:0] S_IDLE = 3'd0, S_SEL = 3'd1, S_LOOK = 3'd2, S_PAY = 3'd3;
   localparam logic [2:0] S_DISP = 3'd4, S_REF = 3'd5;
`ifdef CHANGE_EN
   localparam bit CHG_EN = 1'b1;
`else
   localparam bit CHG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic i_key_valid = 1'b0, i_coin_valid = 1'b0, i_cancel = 1'b0;
   logic [KEY_W-1:0] i_key_code = '0;
   logic [1:0] i_coin_code = '0;
   logic [KEY_W-1:0] o_price_row, o_price_col;
   logic [CREDIT_W-1:0] i_price_val, o_credit, o_change;
   logic i_price_exists;
   logic [2*KEY_W-1:0] o_product;
   logic [2:0] o_state;
   logic o_dispense, o_refund, o_coin_reject, o_sel_error;

   logic [7:0] price_tab [16][16];
   bit exists_tab [16][16];
   int coin_units [4] = '{1, 2, 5, 10};
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // External price table, answered combinationally from the lookup port.
   assign i_price_val    = price_tab[o_price_row][o_price_col];
   assign i_price_exists = exists_tab[o_price_row][o_price_col];

   maquina_vendas_param #(
      .ROWS(ROWS), .COLS(COLS), .KEY_W(KEY_W), .CREDIT_W(CREDIT_W),
      .TIMEOUT_CYC(TO_CYC), .PULSE_CYC(PULSE)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .i_key_valid(i_key_valid), .i_key_code(i_key_code),
      .i_coin_valid(i_coin_valid), .i_coin_code(i_coin_code), .i_cancel(i_cancel),
      .o_price_row(o_price_row), .o_price_col(o_price_col),
      .i_price_val(i_price_val), .i_price_exists(i_price_exists),
      .o_credit(o_credit), .o_product(o_product), .o_state(o_state),
      .o_dispense(o_dispense), .o_refund(o_refund), .o_change(o_change),
      .o_coin_reject(o_coin_reject), .o_sel_error(o_sel_error)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic press(input logic [KEY_W-1:0] k);
      i_key_valid = 1'b1; i_key_code = k;
      tick();
      i_key_valid = 1'b0;
   endtask

   task automatic coin(input logic [1:0] c);
      i_coin_valid = 1'b1; i_coin_code = c;
      tick();
      i_coin_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
   endtask

   // Observe a dispense or refund pulse: cycles until it rises, its length,
   // change at its start (and whether it held), then credit/state afterwards.
   task automatic measure_pulse(input bit want_disp, output int wait_cyc, output int len,
                                output logic [7:0] chg, output bit chg_held,
                                output logic [7:0] cred_after, output logic [2:0] st_after);
      wait_cyc = 0;
      while (((want_disp ? o_dispense : o_refund) !== 1'b1) && wait_cyc < 64) begin
         tick(); wait_cyc++;
      end
      len = 0; chg = o_change; chg_held = 1'b1;
      while (((want_disp ? o_dispense : o_refund) === 1'b1) && len < 64) begin
         if (o_change !== chg) chg_held = 1'b0;
         len++; tick();
      end
      cred_after = o_credit; st_after = o_state;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", o_state, S_IDLE); end
      checks++; if (o_credit !== 8'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", o_credit); end
      checks++; if ({o_dispense, o_refund, o_coin_reject, o_sel_error} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {o_dispense, o_refund, o_coin_reject, o_sel_error}); end
      checks++; if ({o_product, o_price_row, o_price_col, o_change} !== 24'd0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {o_product, o_price_row, o_price_col, o_change}); end
   endtask

   task automatic test_exact_pay();
      int wc, ln; logic [7:0] ch, cr; logic [2:0] st; bit held;
      price_tab[2][3] = 8'd7; exists_tab[2][3] = 1'b1;
      press(4'd2); press(4'd3);
      checks++; if ({o_price_row, o_price_col} !== 8'h23) begin errors++; $display("FAIL exact_lookup_port: got %h expected 23", {o_price_row, o_price_col}); end
      checks++; if (o_state !== S_LOOK) begin errors++; $display("FAIL exact_lookup_state: got %0d expected %0d", o_state, S_LOOK); end
      tick();
      checks++; if (o_state !== S_PAY) begin errors++; $display("FAIL exact_pay_state: got %0d expected %0d", o_state, S_PAY); end
      coin(2'b10);
      checks++; if (o_credit !== 8'd5) begin errors++; $display("FAIL exact_credit5: got %0d expected 5", o_credit); end
      coin(2'b01);
      checks++; if (o_credit !== 8'd7) begin errors++; $display("FAIL exact_credit7: got %0d expected 7", o_credit); end
      checks++; if (o_product !== 8'h23) begin errors++; $display("FAIL exact_product: got %h expected 23", o_product); end
      measure_pulse(1'b1, wc, ln, ch, held, cr, st);
      checks++; if (wc !== 1) begin errors++; $display("FAIL exact_latency: got %0d expected 1", wc); end
      checks++; if (ln !== PULSE) begin errors++; $display("FAIL exact_pulse_len: got %0d expected %0d", ln, PULSE); end
      checks++; if (ch !== 8'd0) begin errors++; $display("FAIL exact_change: got %0d expected 0", ch); end
      checks++; if ({cr, st} !== {8'd0, S_IDLE}) begin errors++; $display("FAIL exact_after: got credit %0d state %0d expected 0 0", cr, st); end
   endtask

   task automatic test_overpay();
      int wc, ln; logic [7:0] ch, cr; logic [2:0] st; bit held;
      price_tab[1][2] = 8'd7; exists_tab[1][2] = 1'b1;
      coin(2'b11);
      checks++; if (o_credit !== 8'd10) begin errors++; $display("FAIL over_credit: got %0d expected 10", o_credit); end
      press(4'd1); press(4'd2); tick();
      checks++; if (o_state !== S_PAY) begin errors++; $display("FAIL over_pay_state: got %0d expected %0d", o_state, S_PAY); end
      measure_pulse(1'b1, wc, ln, ch, held, cr, st);
      checks++; if (wc !== 1) begin errors++; $display("FAIL over_latency: got %0d expected 1", wc); end
      checks++; if (ln !== PULSE) begin errors++; $display("FAIL over_pulse_len: got %0d expected %0d", ln, PULSE); end
      checks++; if (ch !== (CHG_EN ? 8'd3 : 8'd0)) begin errors++; $display("FAIL over_change: got %0d expected %0d", ch, CHG_EN ? 3 : 0); end
      checks++; if (!held) begin errors++; $display("FAIL over_change_held: got 0 expected 1"); end
      checks++; if ({cr, st} !== {8'd0, S_IDLE}) begin errors++; $display("FAIL over_after: got credit %0d state %0d expected 0 0", cr, st); end
   endtask

   task automatic test_invalid_sel();
      press(4'd5);
      checks++; if ({o_sel_error, o_state} !== {1'b1, S_IDLE}) begin errors++; $display("FAIL bad_row: got sel_error %b state %0d expected 1 0", o_sel_error, o_state); end
      tick();
      checks++; if (o_sel_error !== 1'b0) begin errors++; $display("FAIL bad_row_pulse: got %b expected 0", o_sel_error); end
      press(4'd1);
      checks++; if (o_state !== S_SEL) begin errors++; $display("FAIL sel_col_state: got %0d expected %0d", o_state, S_SEL); end
      press(4'd4);
      checks++; if ({o_sel_error, o_state} !== {1'b1, S_IDLE}) begin errors++; $display("FAIL bad_col: got sel_error %b state %0d expected 1 0", o_sel_error, o_state); end
   endtask

   task automatic test_empty_slot();
      int wc, ln; logic [7:0] ch, cr; logic [2:0] st; bit held;
      exists_tab[3][0] = 1'b0;
      coin(2'b01);
      press(4'd3); press(4'd0); tick();
      checks++; if ({o_sel_error, o_state, o_refund} !== {1'b1, S_REF, 1'b1}) begin errors++; $display("FAIL empty_refund: got sel_error %b state %0d refund %b expected 1 5 1", o_sel_error, o_state, o_refund); end
      measure_pulse(1'b0, wc, ln, ch, held, cr, st);
      checks++; if (ln !== PULSE) begin errors++; $display("FAIL empty_refund_len: got %0d expected %0d", ln, PULSE); end
      checks++; if ({cr, st} !== {8'd0, S_IDLE}) begin errors++; $display("FAIL empty_after: got credit %0d state %0d expected 0 0", cr, st); end
      press(4'd3); press(4'd0); tick();
      checks++; if ({o_sel_error, o_state, o_refund} !== {1'b1, S_IDLE, 1'b0}) begin errors++; $display("FAIL empty_nocredit: got sel_error %b state %0d refund %b expected 1 0 0", o_sel_error, o_state, o_refund); end
   endtask

   task automatic test_timeout();
      int wc, ln, n; logic [7:0] ch, cr; logic [2:0] st; bit held;
      price_tab[0][1] = 8'd9; exists_tab[0][1] = 1'b1;
      press(4'd0); press(4'd1); tick();
      coin(2'b00);
      measure_pulse(1'b0, wc, ln, ch, held, cr, st);
      checks++; if (wc !== TO_CYC) begin errors++; $display("FAIL pay_timeout_cycles: got %0d expected %0d", wc, TO_CYC); end
      checks++; if (ln !== PULSE) begin errors++; $display("FAIL pay_timeout_refund_len: got %0d expected %0d", ln, PULSE); end
      checks++; if ({cr, st} !== {8'd0, S_IDLE}) begin errors++; $display("FAIL pay_timeout_after: got credit %0d state %0d expected 0 0", cr, st); end
      press(4'd2);
      n = 0;
      while (o_state !== S_IDLE && n < 64) begin tick(); n++; end
      checks++; if (n !== TO_CYC) begin errors++; $display("FAIL selcol_timeout_cycles: got %0d expected %0d", n, TO_CYC); end
      checks++; if (o_refund !== 1'b0) begin errors++; $display("FAIL selcol_timeout_refund: got %b expected 0", o_refund); end
   endtask

   task automatic test_saturation();
      int wc, ln; logic [7:0] ch, cr; logic [2:0] st; bit held;
      for (int i = 0; i < 25; i++) coin(2'b11);
      checks++; if (o_credit !== 8'd250) begin errors++; $display("FAIL sat_fill: got %0d expected 250", o_credit); end
      coin(2'b11);
      checks++; if ({o_coin_reject, o_credit} !== {1'b1, 8'd250}) begin errors++; $display("FAIL sat_reject: got reject %b credit %0d expected 1 250", o_coin_reject, o_credit); end
      coin(2'b10);
      checks++; if ({o_coin_reject, o_credit} !== {1'b0, 8'd255}) begin errors++; $display("FAIL sat_top: got reject %b credit %0d expected 0 255", o_coin_reject, o_credit); end
      coin(2'b00);
      checks++; if ({o_coin_reject, o_credit} !== {1'b1, 8'd255}) begin errors++; $display("FAIL sat_full: got reject %b credit %0d expected 1 255", o_coin_reject, o_credit); end
      price_tab[0][0] = 8'd200; exists_tab[0][0] = 1'b1;
      press(4'd0); press(4'd0); tick();
      measure_pulse(1'b1, wc, ln, ch, held, cr, st);
      checks++; if (ch !== (CHG_EN ? 8'd55 : 8'd0)) begin errors++; $display("FAIL sat_change: got %0d expected %0d", ch, CHG_EN ? 55 : 0); end
      checks++; if ({wc, ln, cr} !== {32'd1, PULSE, 8'd0}) begin errors++; $display("FAIL sat_dispense: got wait %0d len %0d credit %0d expected 1 %0d 0", wc, ln, cr, PULSE); end
   endtask

   task automatic test_cancel_coin();
      int wc, ln; logic [7:0] ch, cr; logic [2:0] st; bit held;
      coin(2'b00);
      i_cancel = 1'b1; tick(); i_cancel = 1'b0;
      checks++; if ({o_state, o_credit, o_refund} !== {S_IDLE, 8'd1, 1'b0}) begin errors++; $display("FAIL cancel_idle: got state %0d credit %0d refund %b expected 0 1 0", o_state, o_credit, o_refund); end
      price_tab[3][3] = 8'd20; exists_tab[3][3] = 1'b1;
      press(4'd3); press(4'd3); tick();
      coin(2'b10);
      i_cancel = 1'b1; i_coin_valid = 1'b1; i_coin_code = 2'b01;
      tick();
      i_cancel = 1'b0; i_coin_valid = 1'b0;
      checks++; if ({o_state, o_credit, o_refund} !== {S_REF, 8'd8, 1'b1}) begin errors++; $display("FAIL cancel_coin: got state %0d credit %0d refund %b expected 5 8 1", o_state, o_credit, o_refund); end
      measure_pulse(1'b0, wc, ln, ch, held, cr, st);
      checks++; if ({wc, ln, cr, st} !== {32'd0, PULSE, 8'd0, S_IDLE}) begin errors++; $display("FAIL cancel_refund: got wait %0d len %0d credit %0d state %0d expected 0 %0d 0 0", wc, ln, cr, st, PULSE); end
   endtask

   task automatic test_reset_mid();
      price_tab[1][1] = 8'd3; exists_tab[1][1] = 1'b1;
      coin(2'b11);
      press(4'd1); press(4'd1); tick(); tick();
      checks++; if ({o_state, o_dispense} !== {S_DISP, 1'b1}) begin errors++; $display("FAIL mid_dispense: got state %0d dispense %b expected 4 1", o_state, o_dispense); end
      coin(2'b00);
      checks++; if ({o_coin_reject, o_credit} !== {1'b1, 8'd10}) begin errors++; $display("FAIL busy_coin: got reject %b credit %0d expected 1 10", o_coin_reject, o_credit); end
      reset_n = 1'b0; tick();
      checks++; if ({o_dispense, o_credit, o_state, o_product} !== {1'b0, 8'd0, S_IDLE, 8'd0}) begin errors++; $display("FAIL mid_reset: got dispense %b credit %0d state %0d product %h expected 0 0 0 00", o_dispense, o_credit, o_state, o_product); end
      reset_n = 1'b1; tick();
   endtask

   // Random purchases; outcome predicted from credit, price and slot status.
   task automatic test_random();
      int wc, ln, m, price, r, c, v; logic [7:0] ch, cr; logic [2:0] st; bit held, ex, cxl;
      logic [1:0] code;
      m = 0;
      for (int it = 0; it < 40; it++) begin
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            code = 2'($urandom_range(0, 3)); v = coin_units[code];
            coin(code);
            if (m + v <= 255) m += v;
            checks++; if (o_credit !== 8'(m)) begin errors++; $display("FAIL rnd_credit it%0d: got %0d expected %0d", it, o_credit, m); end
         end
         r = $urandom_range(0, ROWS - 1); c = $urandom_range(0, COLS - 1);
         price = $urandom_range(1, 30); ex = ($urandom_range(0, 4) != 0);
         price_tab[r][c] = 8'(price); exists_tab[r][c] = ex;
         press(4'(r)); press(4'(c)); tick();
         if (!ex) begin
            checks++; if ({o_sel_error, o_state} !== {1'b1, (m > 0) ? S_REF : S_IDLE}) begin errors++; $display("FAIL rnd_empty it%0d: got sel_error %b state %0d", it, o_sel_error, o_state); end
            if (m > 0) begin
               measure_pulse(1'b0, wc, ln, ch, held, cr, st);
               checks++; if ({ln, cr} !== {PULSE, 8'd0}) begin errors++; $display("FAIL rnd_empty_refund it%0d: got len %0d credit %0d", it, ln, cr); end
            end
            m = 0;
         end else begin
            checks++; if (o_state !== S_PAY) begin errors++; $display("FAIL rnd_pay it%0d: got %0d expected %0d", it, o_state, S_PAY); end
            cxl = (m < price) && ($urandom_range(0, 3) == 0);
            if (cxl) begin
               i_cancel = 1'b1; tick(); i_cancel = 1'b0;
               checks++; if (o_state !== ((m > 0) ? S_REF : S_IDLE)) begin errors++; $display("FAIL rnd_cancel it%0d: got %0d", it, o_state); end
               if (m > 0) measure_pulse(1'b0, wc, ln, ch, held, cr, st);
            end else begin
               while (m < price) begin
                  code = 2'($urandom_range(0, 3)); m += coin_units[code];
                  coin(code);
               end
               measure_pulse(1'b1, wc, ln, ch, held, cr, st);
               checks++; if ({wc, ln} !== {32'd1, PULSE}) begin errors++; $display("FAIL rnd_dispense it%0d: got wait %0d len %0d expected 1 %0d", it, wc, ln, PULSE); end
               checks++; if (ch !== (CHG_EN ? 8'(m - price) : 8'd0)) begin errors++; $display("FAIL rnd_change it%0d: got %0d credit %0d price %0d", it, ch, m, price); end
            end
            checks++; if ({o_credit, o_state} !== {8'd0, S_IDLE}) begin errors++; $display("FAIL rnd_after it%0d: got credit %0d state %0d", it, o_credit, o_state); end
            m = 0;
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            price_tab[a][b] = 8'd0; exists_tab[a][b] = 1'b0;
         end
      test_reset();
      test_exact_pay();
      test_overpay();
      test_invalid_sel();
      test_empty_slot();
      test_timeout();
      test_saturation();
      test_cancel_coin();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
